// File: rtl/shift_ser_pkg.sv
// shift_ser_pkg: shared state encoding, width constant and requester index
// type for the shift_ser_ctrl slice.
package shift_ser_pkg;

   localparam int SER_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_e;

   typedef logic req_idx_t;

   // Index of the granted requester from a one-hot (or zero) two-bit grant.
   function automatic req_idx_t gnt_to_idx(input logic [1:0] gnt);
      return gnt[1];
   endfunction

endpackage

// File: rtl/shift_ser_ctrl_if.sv
// shift_ser_ctrl_if: word-request side and serial-stream side of the
// shift_ser_ctrl block. The controller uses the slave modport, the word
// producers / serial consumer environment uses the master modport.
interface shift_ser_ctrl_if
   import shift_ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH
);

   logic [1:0]       req_valid;
   logic [WIDTH-1:0] req_data0;
   logic [WIDTH-1:0] req_data1;
   logic [1:0]       req_ready;
   logic             ser_valid;
   logic             ser_bit;
   logic             ser_last;
   req_idx_t         ser_src;

   modport slave (
      input  req_valid, req_data0, req_data1,
      output req_ready, ser_valid, ser_bit, ser_last, ser_src
   );

   modport master (
      output req_valid, req_data0, req_data1,
      input  req_ready, ser_valid, ser_bit, ser_last, ser_src
   );

endinterface

// File: rtl/shift_ser_ctrl_arb.sv
// rr_arb2: two-input arbiter for shift_ser_ctrl. Grant is combinational on
// req; the pointer only moves when the caller reports a handshake (advance).
// SHIFT_SER_CTRL_FIXED_PRIO_EN selects fixed priority (requester 0 wins)
// and removes the pointer; the default build is round-robin.
module rr_arb2
   import shift_ser_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

`ifdef SHIFT_SER_CTRL_FIXED_PRIO_EN

   logic arb_unused_s;
   assign arb_unused_s = &{1'b0, clk, reset_n, advance};

   // Fixed priority grant: requester 0 wins any contention.
   always_comb begin
      if (req[0]) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end else begin
         gnt = 2'b00;
      end
   end

`else

   req_idx_t ptr_q;
   req_idx_t ptr_d;

   // Pointer register: the requester favoured at the next contention.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Grant: a lone requester always wins, contention goes to the pointer.
   always_comb begin
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // Pointer update: after an accepted grant, favour the other requester;
   // a withdrawn request leaves it untouched.
   always_comb begin
      if (advance) begin
         ptr_d = ~gnt_to_idx(gnt);
      end else begin
         ptr_d = ptr_q;
      end
   end

`endif

endmodule

// File: rtl/shift_ser_ctrl.sv
// shift_ser_ctrl: shares one WIDTH-bit MSB-first shift register between two
// word producers. Arbitrates a word, pulses sr_load for one cycle, then frames
// the shifted MSB as a serial stream with valid/last/source markers.
// Build option SHIFT_SER_CTRL_FIXED_PRIO_EN (inside rr_arb2) swaps the
// round-robin arbiter for fixed priority; everything else is unchanged.
module shift_ser_ctrl
   import shift_ser_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
)(
   input  logic             clk,
   input  logic             reset_n,
   shift_ser_ctrl_if.slave  bus,
   output logic             sr_load,
   output logic [WIDTH-1:0] sr_data,
   input  logic [WIDTH-1:0] sr_q,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   req_idx_t         src_q, src_d;
   logic             load_q, load_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;

   logic [1:0]       gnt_s;
   logic [1:0]       ready_s;
   logic             open_s;
   logic             hs_s;
   logic             cnt_last_s;
   logic [WIDTH-1:0] word_s;
   logic             sr_unused_s;

   // Only the MSB of the shift register feeds the serial stream.
   assign sr_unused_s = &{1'b0, sr_q[WIDTH-2:0]};

   // Accept window: idle, or the final shift cycle so words can run
   // back-to-back with a single LOAD bubble. Forced shut during reset.
   assign cnt_last_s = (cnt_q == CNT_W'(WIDTH-1));
   assign open_s     = reset_n & ((state_q == ST_IDLE) |
                                  ((state_q == ST_SHIFT) & cnt_last_s));
   assign ready_s    = open_s ? gnt_s : 2'b00;
   assign hs_s       = |(bus.req_valid & ready_s);
   assign word_s     = ready_s[1] ? bus.req_data1 : bus.req_data0;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (bus.req_valid),
      .advance (hs_s),
      .gnt     (gnt_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: IDLE -> LOAD on accept, LOAD -> SHIFT, SHIFT runs
   // WIDTH cycles and then reloads on a fresh accept or returns to IDLE.
   always_comb begin
      case (state_q)
         ST_IDLE:  state_d = hs_s ? ST_LOAD : ST_IDLE;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt_last_s) begin
               state_d = hs_s ? ST_LOAD : ST_IDLE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: hold word and owner on accept, count the shifts.
   always_comb begin
      if (hs_s) begin
         hold_d = word_s;
         src_d  = gnt_to_idx(ready_s);
      end else begin
         hold_d = hold_q;
         src_d  = src_q;
      end
      case (state_q)
         ST_LOAD:  cnt_d = '0;
         ST_SHIFT: cnt_d = cnt_q + CNT_W'(1);
         default:  cnt_d = cnt_q;
      endcase
   end

   // FSM output decode, computed from the next state so flags are registered.
   always_comb begin
      load_d  = (state_d == ST_LOAD);
      valid_d = (state_d == ST_SHIFT);
      last_d  = (state_d == ST_SHIFT) && (cnt_d == CNT_W'(WIDTH-1));
      busy_d  = (state_d != ST_IDLE);
   end

   // Datapath and output flag registers; all clear on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         hold_q  <= '0;
         src_q   <= 1'b0;
         load_q  <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         src_q   <= src_d;
         load_q  <= load_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.ser_valid = valid_q;
   assign bus.ser_bit   = valid_q & sr_q[WIDTH-1];
   assign bus.ser_last  = last_q;
   assign bus.ser_src   = src_q;
   assign sr_load       = load_q;
   assign sr_data       = hold_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// tb_shift_ser_ctrl: directed scenarios plus randomized traffic, with a
// 4-bit shift register on the sr_* pins. Expected outputs come from a
// word-level model that tracks cycles elapsed since each accept.
module tb_shift_ser_ctrl;
   import shift_ser_pkg::*;

   localparam int W = SER_WIDTH;

   logic         clk;
   logic         reset_n;
   logic         sr_load;
   logic [W-1:0] sr_data;
   logic [W-1:0] sr_q;
   logic [W-1:0] sr_reg;
   logic         busy;

   shift_ser_ctrl_if #(.WIDTH(W)) bus ();

   shift_ser_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .sr_load (sr_load),
      .sr_data (sr_data),
      .sr_q    (sr_q),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The shared shift register: parallel load or shift left every cycle.
   always @(posedge clk) begin
      if (sr_load) sr_reg <= sr_data;
      else         sr_reg <= {sr_reg[W-2:0], 1'b0};
   end
   assign sr_q = sr_reg;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: m_age = cycles since the accept edge (0 = idle).
   int           m_age;
   logic [W-1:0] m_word, m_sdata;
   logic         m_src, m_ptr;
   logic [1:0]   m_ready, m_last_hs;

   logic bits_q[$];
   logic grants_q[$];

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] pick(input logic [1:0] v);
      if (v == 2'b11) begin
`ifdef SHIFT_SER_CTRL_FIXED_PRIO_EN
         return 2'b01;
`else
         return m_ptr ? 2'b10 : 2'b01;
`endif
      end
      return v;
   endfunction

   task automatic model_reset();
      m_age = 0; m_word = '0; m_sdata = '0; m_src = 1'b0; m_ptr = 1'b0;
      m_ready = 2'b00; m_last_hs = 2'b00;
   endtask

   task automatic check_all();
      logic exp_bit;
      m_ready = ((m_age == 0) || (m_age == W+1)) ? pick(bus.req_valid) : 2'b00;
      exp_bit = 1'b0;
      if (m_age >= 2) exp_bit = m_word[W+1-m_age];
      check_eq("req_ready", 8'(bus.req_ready), 8'(m_ready));
      check_eq("busy",      8'(busy),          8'(m_age != 0));
      check_eq("sr_load",   8'(sr_load),       8'(m_age == 1));
      check_eq("sr_data",   8'(sr_data),       8'(m_sdata));
      check_eq("ser_valid", 8'(bus.ser_valid), 8'(m_age >= 2));
      check_eq("ser_bit",   8'(bus.ser_bit),   8'(exp_bit));
      check_eq("ser_last",  8'(bus.ser_last),  8'(m_age == W+1));
      check_eq("ser_src",   8'(bus.ser_src),   8'(m_src));
   endtask

   task automatic model_step();
      m_last_hs = m_ready & bus.req_valid;
      if (m_last_hs != 2'b00) begin
         m_src   = m_last_hs[1];
         m_word  = m_last_hs[1] ? bus.req_data1 : bus.req_data0;
         m_sdata = m_word;
         m_ptr   = ~m_last_hs[1];
         m_age   = 1;
      end else if (m_age == W+1) begin
         m_age = 0;
      end else if (m_age != 0) begin
         m_age = m_age + 1;
      end else begin
         m_age = 0;
      end
   endtask

   task automatic cycle(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1);
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.req_data0 = d0;
      bus.req_data1 = d1;
      #1;
      check_all();
      if (bus.ser_valid) bits_q.push_back(bus.ser_bit);
      if ((bus.req_valid & bus.req_ready) != 2'b00) grants_q.push_back(bus.req_ready[1]);
      model_step();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(2'b00, '0, '0);
   endtask

   logic [W-1:0] exp_w;
   logic [7:0]   exp_bits;
   logic [3:0]   exp_g;
   logic [1:0]   rv;
   logic [W-1:0] rd [2];

   initial begin
      reset_n = 1'b0;
      bus.req_valid = 2'b00;
      bus.req_data0 = '0;
      bus.req_data1 = '0;
      model_reset();
      #2;
      check_all();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Contention from a fresh reset: A from 0, 5 from 1, four words.
      grants_q.delete(); bits_q.delete();
      for (int k = 0; k < 20; k++) cycle(2'b11, 4'hA, 4'h5);
      idle(6);
`ifdef SHIFT_SER_CTRL_FIXED_PRIO_EN
      exp_g = 4'b0000;
`else
      exp_g = 4'b1010;
`endif
      check_eq("cont_ngrants", 8'(grants_q.size()), 8'd4);
      for (int j = 0; j < 4 && j < grants_q.size(); j++)
         check_eq("cont_grant", 8'(grants_q[j]), 8'(exp_g[j]));
      check_eq("cont_nbits", 8'(bits_q.size()), 8'd16);

      // Single word 1011 from requester 0.
      bits_q.delete();
      cycle(2'b01, 4'b1011, 4'h0);
      idle(6);
      exp_w = 4'b1011;
      check_eq("sw_nbits", 8'(bits_q.size()), 8'd4);
      for (int j = 0; j < 4 && j < bits_q.size(); j++)
         check_eq("sw_bit", 8'(bits_q[j]), 8'(exp_w[3-j]));

      // Back-to-back from requester 1: 3 then C, accepted on the last shift.
      bits_q.delete();
      cycle(2'b10, 4'h0, 4'h3);
      for (int k = 0; k < 5; k++) cycle(2'b10, 4'h0, 4'hC);
      idle(7);
      exp_bits = 8'b0011_1100;
      check_eq("b2b_nbits", 8'(bits_q.size()), 8'd8);
      for (int j = 0; j < 8 && j < bits_q.size(); j++)
         check_eq("b2b_bit", 8'(bits_q[j]), 8'(exp_bits[7-j]));

      // Reset on the second shift bit: outputs clear at once, r0 wins after.
      cycle(2'b01, 4'hB, 4'h0);
      idle(3);
      reset_n = 1'b0;
      bus.req_valid = 2'b00;
      model_reset();
      #1;
      check_all();
      check_eq("rst_ser_last", 8'(bus.ser_last), 8'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      grants_q.delete();
      cycle(2'b11, 4'hA, 4'h5);
      idle(6);
      check_eq("rst_ngrants", 8'(grants_q.size()), 8'd1);
      if (grants_q.size() > 0) check_eq("rst_first_gnt", 8'(grants_q[0]), 8'd0);

      // Withdraw: r1 requests while busy, drops before the accept window.
      grants_q.delete();
      cycle(2'b01, 4'h6, 4'h0);
      for (int k = 0; k < 2; k++) cycle(2'b10, 4'h0, 4'h9);
      idle(4);
      cycle(2'b11, 4'h6, 4'h9);
      idle(6);
`ifdef SHIFT_SER_CTRL_FIXED_PRIO_EN
      exp_g = 4'b0000;
`else
      exp_g = 4'b0010;
`endif
      check_eq("wd_ngrants", 8'(grants_q.size()), 8'd2);
      for (int j = 0; j < 2 && j < grants_q.size(); j++)
         check_eq("wd_grant", 8'(grants_q[j]), 8'(exp_g[j]));

      // Randomized traffic honouring the data-stable-until-accepted rule.
      rv = 2'b00; rd[0] = '0; rd[1] = '0;
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (rv[i]) begin
               if ($urandom_range(0, 9) == 0) rv[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               rv[i] = 1'b1;
               rd[i] = W'($urandom_range(0, 15));
            end
         end
         cycle(rv, rd[0], rd[1]);
         for (int i = 0; i < 2; i++) begin
            if (m_last_hs[i]) begin
               rv[i] = 1'($urandom_range(0, 1));
               rd[i] = W'($urandom_range(0, 15));
            end
         end
      end
      idle(8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
